// File: rtl/strhw_acc_if.sv
// Shared state type and handshake/data interface of the Streebog stage-2 accumulator.
package strhw_acc_pkg;
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

interface strhw_acc_if;
   import strhw_acc_pkg::*;

   logic         trg_i;
   logic [511:0] m_i;
   logic [511:0] n_i;
   logic [511:0] sigma_i;
   logic [9:0]   len_i;
   logic [511:0] n_o;
   logic [511:0] sigma_o;
   state_t       state_o;

   modport master (
      output trg_i, m_i, n_i, sigma_i, len_i,
      input  n_o, sigma_o, state_o
   );

   modport slave (
      input  trg_i, m_i, n_i, sigma_i, len_i,
      output n_o, sigma_o, state_o
   );
endinterface

// File: rtl/strhw_acc.sv
// Streebog stage-2 accumulator: N' = N + len, Sigma' = Sigma + m (mod 2^512), chunked ripple add.
// Define STRHW_ACC_SINGLE_CYCLE_EN to do the full 512-bit add in one cycle instead.
module strhw_acc
   import strhw_acc_pkg::*;
#(
   parameter int CHUNK_W = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   strhw_acc_if.slave bus
);

`ifdef STRHW_ACC_SINGLE_CYCLE_EN
   localparam int SLICE_W = 512;
`else
   localparam int SLICE_W = CHUNK_W;
`endif
   localparam int NCHUNK = 512 / SLICE_W;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic {IDLE, ADD} fsm_t;

   fsm_t   fsm_q, fsm_d;
   state_t state_d;
   logic   start, last;

   logic [511:0]  m_lat, n_lat, s_lat;
   logic [9:0]    len_lat;
   logic [511:0]  n_part, s_part;
   logic [KW-1:0] k_q;
   logic          carry_n_q, carry_s_q;

   logic [9:0]         len_sat;
   logic [511:0]       len_ext;
   logic [9:0]         base;
   logic [SLICE_W-1:0] n_slice, s_slice;
   logic               c_n, c_s;
   logic [511:0]       n_full, s_full;

   // Oversized lengths clamp to a full block before they are ever stored.
   assign len_sat = (bus.len_i > 10'd512) ? 10'd512 : bus.len_i;
   assign len_ext = {502'd0, len_lat};
   assign base    = 10'(int'(k_q) * SLICE_W);

   assign {c_n, n_slice} = {1'b0, n_lat[base +: SLICE_W]}
                         + {1'b0, len_ext[base +: SLICE_W]}
                         + {{SLICE_W{1'b0}}, carry_n_q};
   assign {c_s, s_slice} = {1'b0, s_lat[base +: SLICE_W]}
                         + {1'b0, m_lat[base +: SLICE_W]}
                         + {{SLICE_W{1'b0}}, carry_s_q};

   // Full result as seen by the current edge: stored low slices plus the slice being added now.
   always_comb begin
      n_full = n_part;
      s_full = s_part;
      n_full[base +: SLICE_W] = n_slice;
      s_full[base +: SLICE_W] = s_slice;
   end

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = bus.state_o;
      start   = 1'b0;
      last    = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (bus.trg_i) begin
               start   = 1'b1;
               fsm_d   = ADD;
               state_d = BUSY;
            end
         end
         ADD: begin
            if (k_q == K_LAST) begin
               last    = 1'b1;
               fsm_d   = IDLE;
               state_d = DONE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q       <= IDLE;
         bus.state_o <= CLEAR;
      end else begin
         fsm_q       <= fsm_d;
         bus.state_o <= state_d;
      end
   end

   // NOTE: the wide operand and partial-sum registers are reset too, so an aborted add leaves no residue.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_lat       <= '0;
         n_lat       <= '0;
         s_lat       <= '0;
         len_lat     <= '0;
         n_part      <= '0;
         s_part      <= '0;
         k_q         <= '0;
         carry_n_q   <= 1'b0;
         carry_s_q   <= 1'b0;
         bus.n_o     <= '0;
         bus.sigma_o <= '0;
      end else if (start) begin
         m_lat     <= bus.m_i;
         n_lat     <= bus.n_i;
         s_lat     <= bus.sigma_i;
         len_lat   <= len_sat;
         k_q       <= '0;
         carry_n_q <= 1'b0;
         carry_s_q <= 1'b0;
      end else if (fsm_q == ADD) begin
         n_part    <= n_full;
         s_part    <= s_full;
         carry_n_q <= c_n;
         carry_s_q <= c_s;
         k_q       <= k_q + 1'b1;
         // The carry out of bit 511 is simply dropped, giving the mod 2^512 wrap.
         if (last) begin
            bus.n_o     <= n_full;
            bus.sigma_o <= s_full;
         end
      end
   end

endmodule

// File: tb/tb_strhw_acc.sv
// Self-checking bench for strhw_acc: directed corner cases plus random blocks against a big-integer model.
module tb_strhw_acc;
   import strhw_acc_pkg::*;

`ifdef STRHW_ACC_SINGLE_CYCLE_EN
   localparam int NCH = 1;
`else
   localparam int NCH = 512 / 64;
`endif

   logic clk_i = 1'b0;
   logic rst_i;

   strhw_acc_if bus ();

   strhw_acc #(.CHUNK_W(64)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Model state: the last completed result, which the outputs must show until the next completion.
   logic [511:0] exp_n = '0;
   logic [511:0] exp_s = '0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] ref_n(input logic [511:0] n, input logic [9:0] len);
      logic [511:0] l;
      l = (len > 10'd512) ? 512'd512 : 512'(len);
      return n + l;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Called just after the start edge; counts edges until DONE, checking outputs hold meanwhile.
   task automatic wait_done(input string tag, input int pulse_at);
      int cyc;
      cyc = 0;
      while (bus.state_o != DONE && cyc < 64) begin
         check({tag, "_hold_n"}, bus.n_o, exp_n);
         check({tag, "_hold_s"}, bus.sigma_o, exp_s);
         if (cyc == pulse_at) begin
            bus.trg_i   = 1'b1;
            bus.n_i     = rnd512();
            bus.sigma_i = rnd512();
         end
         tick();
         cyc++;
         if (cyc == pulse_at + 1) bus.trg_i = 1'b0;
      end
      check({tag, "_latency"}, 512'(cyc), 512'(NCH));
      check({tag, "_done"}, 512'(bus.state_o), 512'(DONE));
   endtask

   task automatic do_op(input string tag, input logic [511:0] n, input logic [511:0] s,
                        input logic [511:0] m, input logic [9:0] len, input int pulse_at);
      logic [511:0] nn, ss;
      nn = ref_n(n, len);
      ss = s + m;
      bus.n_i     = n;
      bus.sigma_i = s;
      bus.m_i     = m;
      bus.len_i   = len;
      bus.trg_i   = 1'b1;
      tick();
      bus.trg_i   = 1'b0;
      check({tag, "_busy"}, 512'(bus.state_o), 512'(BUSY));
      bus.n_i     = rnd512();
      bus.sigma_i = rnd512();
      bus.m_i     = rnd512();
      bus.len_i   = 10'($urandom);
      wait_done(tag, pulse_at);
      check({tag, "_n"}, bus.n_o, nn);
      check({tag, "_sigma"}, bus.sigma_o, ss);
      exp_n = nn;
      exp_s = ss;
   endtask

   initial begin
      logic [511:0] ones, c64, cur_n, cur_s, mm, nn, ss;
      logic [9:0]   ll;
      ones = '1;
      c64  = {448'd0, 64'hFFFF_FFFF_FFFF_FFFF};

      bus.trg_i   = 1'b0;
      bus.n_i     = '0;
      bus.sigma_i = '0;
      bus.m_i     = '0;
      bus.len_i   = '0;
      rst_i       = 1'b1;
      #3;
      check("rst_state", 512'(bus.state_o), 512'(CLEAR));
      check("rst_n", bus.n_o, '0);
      check("rst_sigma", bus.sigma_o, '0);
      #9 rst_i = 1'b0;
      tick();
      check("idle_clear", 512'(bus.state_o), 512'(CLEAR));

      do_op("basic", '0, '0, 512'd1, 10'd512, -1);
      tick();
      check("done_stays", 512'(bus.state_o), 512'(DONE));

      do_op("carry64", rnd512(), c64, 512'd1, 10'($urandom_range(0, 512)), -1);
      do_op("wrap", ones, ones, 512'd1, 10'd1, -1);
      do_op("sat", 512'd5, rnd512(), rnd512(), 10'd700, -1);
      do_op("len0", 512'd5, rnd512(), rnd512(), 10'd0, -1);
      do_op("trg_in_busy", rnd512(), rnd512(), rnd512(), 10'($urandom_range(0, 1023)), 2);

      for (int i = 0; i < 6; i++)
         do_op("rand", rnd512(), rnd512(), rnd512(), 10'($urandom_range(0, 1023)), -1);

      // trg held high: each block restarts on its DONE cycle with N/Sigma fed back from the model.
      cur_n       = rnd512();
      cur_s       = rnd512();
      mm          = rnd512();
      ll          = 10'($urandom_range(0, 600));
      bus.n_i     = cur_n;
      bus.sigma_i = cur_s;
      bus.m_i     = mm;
      bus.len_i   = ll;
      bus.trg_i   = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         nn = ref_n(cur_n, ll);
         ss = cur_s + mm;
         wait_done("held", -1);
         check("held_n", bus.n_o, nn);
         check("held_sigma", bus.sigma_o, ss);
         exp_n = nn;
         exp_s = ss;
         cur_n = nn;
         cur_s = ss;
         if (i < 2) begin
            bus.n_i     = cur_n;
            bus.sigma_i = cur_s;
            tick();
            check("held_restart", 512'(bus.state_o), 512'(BUSY));
         end else begin
            bus.trg_i = 1'b0;
         end
      end

      // Reset in the middle of an operation, between clock edges.
      bus.n_i     = rnd512();
      bus.sigma_i = rnd512();
      bus.m_i     = rnd512();
      bus.len_i   = 10'd512;
      bus.trg_i   = 1'b1;
      tick();
      bus.trg_i = 1'b0;
      repeat (3) tick();
      #2 rst_i = 1'b1;
      #1;
      check("midrst_state", 512'(bus.state_o), 512'(CLEAR));
      check("midrst_n", bus.n_o, '0);
      check("midrst_sigma", bus.sigma_o, '0);
      exp_n = '0;
      exp_s = '0;
      #2 rst_i = 1'b0;
      tick();
      check("midrst_idle", 512'(bus.state_o), 512'(CLEAR));
      tick();
      check("midrst_no_result", bus.n_o, '0);
      do_op("after_rst", rnd512(), rnd512(), rnd512(), 10'($urandom_range(0, 512)), -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
